// File: rtl/exec_pkg.sv
// Shared definitions for the multi-lane execute stage.
//   - ALU operation encodings (shared with alu)
//   - forward-select code bases as functions of the lane count
//   - per-lane multiplier FSM state encoding
// Optional feature macro used by the stage: EXEC_INTRA_FWD_EN.
package exec_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_NOR  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    // Select code 0 is the register file; MEM results start at 1.
    localparam int FWD_MEM_BASE = 1;

    function automatic int fwd_wb_base(input int lanes);
        return lanes + 1;
    endfunction

    function automatic int fwd_intra_base(input int lanes);
        return 2 * lanes + 1;
    endfunction

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_BUSY = 2'd1,
        M_DONE = 2'd2
    } mstate_t;

endpackage

// File: rtl/alu.sv
// Combinational single-lane ALU.
//   a, b : operands
//   op   : operation (exec_pkg ALU_* encodings)
//   y    : result, arithmetic wraps modulo 2^XLEN
module alu
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/execute_multilane_mult_seq.sv
// mult_seq: one-lane iterative shift-add multiplier.
//   clk, reset_n : clock, async active-low reset
//   flush        : abort any multiply, return to IDLE
//   req          : lane holds a valid multiply this cycle
//   sgn          : signed operation
//   a, b         : operands, captured when the multiply starts
//   done         : high for the single DONE cycle
//   y            : low XLEN bits of the product, held until the next start
module mult_seq
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            req,
    input  logic            sgn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] y
);

    localparam int CW = $clog2(XLEN) + 1;

    mstate_t         state, state_nx;
    logic [XLEN-1:0] acc, mcand, mplier;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic            start;

    assign start = req & ~flush & (state == M_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= M_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            M_IDLE:  if (start) state_nx = M_BUSY;
            M_BUSY:  if (cnt == CW'(XLEN - 1)) state_nx = M_DONE;
            M_DONE:  state_nx = M_IDLE;
            default: state_nx = M_IDLE;
        endcase
        if (flush) state_nx = M_IDLE;
    end

    // Magnitudes are multiplied and the sign fixed up at the end; only the
    // low XLEN bits are kept, so the partial-product register is XLEN wide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= (sgn & a[XLEN-1]) ? -a : a;
            mplier <= (sgn & b[XLEN-1]) ? -b : b;
            cnt    <= '0;
            neg    <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
        end else if (state == M_BUSY) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign done = (state == M_DONE);
    assign y    = neg ? -acc : acc;

endmodule

// File: rtl/execute_multilane.sv
// execute_multilane: N-lane execute stage with registered EX/MEM outputs.
//   Inputs : ID/EX bundle (valid_e, signe, multsele, alusrce, regdste,
//            alucontrole, rte, rde, signimme, rdata_a/b), forwarding sources
//            (aluoutm, resultw) and selects (forwardae/be), flush.
//   Outputs: valid_m, solution_m, writedata_m, writereg_m (EX/MEM register),
//            stall_o (bundle holding, freeze upstream), multready (per-lane
//            multiplier completion pulse).
// Macro EXEC_INTRA_FWD_EN: when defined, select codes 2*LANES+1..3*LANES
// forward the same-cycle result of a lower lane; otherwise they select 0.
module execute_multilane
    import exec_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int REGW  = 5,
    parameter int FSELW = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [LANES-1:0]             valid_e,
    input  logic [LANES-1:0]             signe,
    input  logic [LANES-1:0]             multsele,
    input  logic [LANES-1:0]             alusrce,
    input  logic [LANES-1:0]             regdste,
    input  logic [LANES-1:0][2:0]        alucontrole,
    input  logic [LANES-1:0][REGW-1:0]   rte,
    input  logic [LANES-1:0][REGW-1:0]   rde,
    input  logic [LANES-1:0][XLEN-1:0]   signimme,
    input  logic [LANES-1:0][XLEN-1:0]   rdata_a,
    input  logic [LANES-1:0][XLEN-1:0]   rdata_b,
    input  logic [LANES-1:0][XLEN-1:0]   aluoutm,
    input  logic [LANES-1:0][XLEN-1:0]   resultw,
    input  logic [LANES-1:0][FSELW-1:0]  forwardae,
    input  logic [LANES-1:0][FSELW-1:0]  forwardbe,
    output logic [LANES-1:0]             valid_m,
    output logic [LANES-1:0][XLEN-1:0]   solution_m,
    output logic [LANES-1:0][XLEN-1:0]   writedata_m,
    output logic [LANES-1:0][REGW-1:0]   writereg_m,
    output logic                         stall_o,
    output logic [LANES-1:0]             multready
);

    logic [LANES-1:0][XLEN-1:0] lane_res;
    logic [LANES-1:0][XLEN-1:0] fwd_b;
    logic [LANES-1:0][REGW-1:0] wreg;
    logic [LANES-1:0]           hold;

    // Undefined select codes fall through to 0.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [FSELW-1:0]           sel,
        input logic [XLEN-1:0]            rd,
        input logic [LANES-1:0][XLEN-1:0] mem,
        input logic [LANES-1:0][XLEN-1:0] wb,
        input logic [LANES-1:0][XLEN-1:0] intra
    );
        logic [XLEN-1:0] r;
        r = (sel == '0) ? rd : '0;
        for (int j = 0; j < LANES; j++) begin
            if (sel == FSELW'(FWD_MEM_BASE + j))             r = mem[j];
            if (sel == FSELW'(fwd_wb_base(LANES) + j))       r = wb[j];
            if (sel == FSELW'(fwd_intra_base(LANES) + j))    r = intra[j];
        end
        return r;
    endfunction

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [LANES-1:0][XLEN-1:0] intra;
        logic [XLEN-1:0]            opa, opb, alu_y, mul_y;
        logic                       mul_done;

`ifdef EXEC_INTRA_FWD_EN
        // Only lower lanes are visible, so the chain stays acyclic.
        for (genvar j = 0; j < LANES; j++) begin : g_intra
            if (j < k) begin : g_lo
                assign intra[j] = lane_res[j];
            end else begin : g_hi
                assign intra[j] = '0;
            end
        end
`else
        assign intra = '0;
`endif

        assign opa      = fwd_mux(forwardae[k], rdata_a[k], aluoutm, resultw, intra);
        assign fwd_b[k] = fwd_mux(forwardbe[k], rdata_b[k], aluoutm, resultw, intra);
        assign opb      = alusrce[k] ? signimme[k] : fwd_b[k];
        assign wreg[k]  = regdste[k] ? rde[k] : rte[k];

        alu #(.XLEN(XLEN)) u_alu (
            .a  (opa),
            .b  (opb),
            .op (alucontrole[k]),
            .y  (alu_y)
        );

        mult_seq #(.XLEN(XLEN)) u_mult (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .req     (valid_e[k] & multsele[k]),
            .sgn     (signe[k]),
            .a       (opa),
            .b       (opb),
            .done    (mul_done),
            .y       (mul_y)
        );

        assign lane_res[k]  = (valid_e[k] & multsele[k]) ? mul_y : alu_y;
        assign hold[k]      = valid_e[k] & multsele[k] & ~mul_done;
        assign multready[k] = mul_done;
    end

    // Gated by reset so the stall reads 0 while reset is held.
    assign stall_o = reset_n & (|hold);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_m     <= '0;
            solution_m  <= '0;
            writedata_m <= '0;
            writereg_m  <= '0;
        end else if (stall_o) begin
            valid_m <= '0;
        end else begin
            valid_m     <= valid_e & {LANES{~flush}};
            solution_m  <= lane_res;
            writedata_m <= fwd_b;
            writereg_m  <= wreg;
        end
    end

endmodule

// File: tb/tb_execute_multilane.sv
// Self-checking bench for execute_multilane: directed cases with literal
// expectations, then randomized bundles checked every cycle against a
// bundle-level reference model.
module tb_execute_multilane;
    import exec_pkg::*;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
    localparam int REGW  = 5;
    localparam int FSELW = 4;
    localparam int IB    = 2 * LANES + 1;  // first same-bundle forward code

    logic                        clk = 1'b0;
    logic                        reset_n = 1'b0;
    logic                        flush = 1'b0;
    logic [LANES-1:0]            valid_e = '0, signe = '0, multsele = '0, alusrce = '0, regdste = '0;
    logic [LANES-1:0][2:0]       alucontrole = '0;
    logic [LANES-1:0][REGW-1:0]  rte = '0, rde = '0;
    logic [LANES-1:0][XLEN-1:0]  signimme = '0, rdata_a = '0, rdata_b = '0, aluoutm = '0, resultw = '0;
    logic [LANES-1:0][FSELW-1:0] forwardae = '0, forwardbe = '0;
    logic [LANES-1:0]            valid_m, multready;
    logic [LANES-1:0][XLEN-1:0]  solution_m, writedata_m;
    logic [LANES-1:0][REGW-1:0]  writereg_m;
    logic                        stall_o;

    int n_checks = 0;
    int n_fail   = 0;

    execute_multilane #(.LANES(LANES), .XLEN(XLEN), .REGW(REGW), .FSELW(FSELW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .valid_e(valid_e), .signe(signe), .multsele(multsele), .alusrce(alusrce),
        .regdste(regdste), .alucontrole(alucontrole), .rte(rte), .rde(rde),
        .signimme(signimme), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .aluoutm(aluoutm), .resultw(resultw), .forwardae(forwardae), .forwardbe(forwardbe),
        .valid_m(valid_m), .solution_m(solution_m), .writedata_m(writedata_m),
        .writereg_m(writereg_m), .stall_o(stall_o), .multready(multready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] alu_ref(input logic [2:0] op, input logic [XLEN-1:0] a, b);
        case (op)
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLTU: return (a < b) ? 1 : 0;
            ALU_SUB:  return a - b;
            default:  return ($signed(a) < $signed(b)) ? 1 : 0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] pick(input int s, input logic [XLEN-1:0] rd, input int k,
                                             input logic [LANES-1:0][XLEN-1:0] res);
        logic [XLEN-1:0] r;
        r = (s == 0) ? rd : '0;
        for (int j = 0; j < LANES; j++) begin
            if (s == 1 + j)         r = aluoutm[j];
            if (s == LANES + 1 + j) r = resultw[j];
`ifdef EXEC_INTRA_FWD_EN
            if (s == IB + j && j < k) r = res[j];
`endif
        end
        return r;
    endfunction

    // Product mod 2^XLEN is the same for signed and unsigned operands.
    task automatic lanes_ref(output logic [LANES-1:0][XLEN-1:0] res, output logic [LANES-1:0][XLEN-1:0] fb);
        logic [XLEN-1:0] a, b;
        res = '0;
        fb  = '0;
        for (int k = 0; k < LANES; k++) begin
            a     = pick(int'(forwardae[k]), rdata_a[k], k, res);
            fb[k] = pick(int'(forwardbe[k]), rdata_b[k], k, res);
            b     = alusrce[k] ? signimme[k] : fb[k];
            res[k] = (valid_e[k] && multsele[k]) ? a * b : alu_ref(alucontrole[k], a, b);
        end
    endtask

    logic [LANES-1:0]            m_valid = '0;
    logic [LANES-1:0][XLEN-1:0]  m_sol = '0, m_wd = '0;
    logic [LANES-1:0][REGW-1:0]  m_wr = '0;
    bit                          m_active = 0;
    int                          m_cnt = 0;  // cycles since the multiply bundle issued

    always @(negedge clk) begin
        logic [LANES-1:0][XLEN-1:0] res, fb;
        logic [LANES-1:0][REGW-1:0] wr;
        logic [LANES-1:0]           mmask, e_mr;
        bit                         e_stall;
        int                         c;
        if (!reset_n) begin
            m_valid = '0; m_sol = '0; m_wd = '0; m_wr = '0; m_active = 0; m_cnt = 0;
            e_stall = 0; e_mr = '0;
        end else begin
            mmask   = valid_e & multsele;
            c       = m_active ? m_cnt : 0;
            e_stall = (mmask != '0) && (c <= XLEN);
            e_mr    = ((mmask != '0) && (c == XLEN + 1)) ? mmask : '0;
        end
        chk("stall_o", stall_o, e_stall);
        chk("multready", multready, e_mr);
        chk("valid_m", valid_m, m_valid);
        chk("solution_m", solution_m, m_sol);
        chk("writedata_m", writedata_m, m_wd);
        chk("writereg_m", writereg_m, m_wr);
        if (reset_n) begin
            lanes_ref(res, fb);
            for (int k = 0; k < LANES; k++) wr[k] = regdste[k] ? rde[k] : rte[k];
            if (e_stall) begin
                m_valid = '0;
                m_active = !flush;
                m_cnt    = flush ? 0 : c + 1;
            end else begin
                m_valid = flush ? '0 : valid_e;
                m_sol = res; m_wd = fb; m_wr = wr;
                m_active = 0; m_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        valid_e = '0; signe = '0; multsele = '0; alusrce = '0; regdste = '0;
        alucontrole = '0; rte = '0; rde = '0; signimme = '0; rdata_a = '0; rdata_b = '0;
        aluoutm = '0; resultw = '0; forwardae = '0; forwardbe = '0; flush = 1'b0;
    endtask

    // Called at posedge+1 with the bundle on the inputs; returns at posedge+1
    // after the bundle retired or was flushed.
    task automatic run_bundle(input int flush_at, output int nstall, output logic [LANES-1:0] mr);
        nstall = 0;
        mr = '0;
        for (int c = 0; c < 200; c++) begin
            flush = (c == flush_at);
            @(negedge clk);
            if (flush || !stall_o) begin
                mr = multready;
                @(posedge clk); #1;
                flush = 1'b0;
                return;
            end
            nstall++;
            @(posedge clk); #1;
        end
        chk("retire_timeout", 1, 0);
    endtask

    task automatic rand_bundle(output int flush_at);
        int sa, sb;
        for (int k = 0; k < LANES; k++) begin
            valid_e[k]     = ($urandom_range(0, 7) != 0);
            multsele[k]    = ($urandom_range(0, 9) == 0);
            signe[k]       = 1'($urandom_range(0, 1));
            alusrce[k]     = 1'($urandom_range(0, 1));
            regdste[k]     = 1'($urandom_range(0, 1));
            alucontrole[k] = 3'($urandom_range(0, 7));
            rte[k]         = REGW'($urandom);
            rde[k]         = REGW'($urandom);
            signimme[k]    = ($urandom_range(0, 1) != 0) ? $urandom : XLEN'($urandom_range(0, 20));
            rdata_a[k]     = $urandom;
            rdata_b[k]     = ($urandom_range(0, 1) != 0) ? $urandom : XLEN'($urandom_range(0, 20));
            aluoutm[k]     = $urandom;
            resultw[k]     = $urandom;
            sa = $urandom_range(0, 15);
            sb = $urandom_range(0, 15);
            // a multiply captures operands at issue, so keep it off same-bundle sources
            if (multsele[k] && sa >= IB && sa < IB + LANES) sa = 0;
            if (multsele[k] && sb >= IB && sb < IB + LANES) sb = 0;
            forwardae[k] = FSELW'(sa);
            forwardbe[k] = FSELW'(sb);
        end
        flush_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : -1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int ns, fa;
        logic [LANES-1:0] mr;
        idle_inputs();
        #1;
        chk("reset_stall", stall_o, 0);
        chk("reset_valid", valid_m, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // ALU add with immediate
        valid_e = 2'b01; rdata_a[0] = 5; signimme[0] = 7; alusrce[0] = 1; alucontrole[0] = ALU_ADD;
        regdste[0] = 1; rde[0] = 5'd9;
        run_bundle(-1, ns, mr);
        chk("add_sol", solution_m[0], 32'd12);
        chk("add_valid", valid_m[0], 1);
        chk("add_nostall", ns, 0);
        chk("add_wreg", writereg_m[0], 5'd9);

        // MEM forward into lane 1
        idle_inputs();
        valid_e = 2'b10; forwardae[1] = 4'd1; aluoutm[0] = 32'h100;
        alusrce[1] = 1; signimme[1] = 1; alucontrole[1] = ALU_ADD;
        run_bundle(-1, ns, mr);
        chk("memfwd_sol", solution_m[1], 32'h101);

        // signed multiply 7 * -3, with an ALU lane alongside
        idle_inputs();
        valid_e = 2'b11; multsele = 2'b01; signe = 2'b01;
        rdata_a[0] = 7; rdata_b[0] = 32'hFFFFFFFD;
        rdata_a[1] = 2; signimme[1] = 3; alusrce[1] = 1; alucontrole[1] = ALU_ADD;
        run_bundle(-1, ns, mr);
        chk("smul_stall_cycles", ns, 33);
        chk("smul_multready", mr, 2'b01);
        chk("smul_sol", solution_m[0], 32'hFFFFFFEB);
        chk("smul_alu_lane", solution_m[1], 32'd5);
        chk("smul_valid", valid_m, 2'b11);

        // unsigned multiply
        idle_inputs();
        valid_e = 2'b01; multsele = 2'b01; rdata_a[0] = 32'hFFFFFFFF; rdata_b[0] = 2;
        run_bundle(-1, ns, mr);
        chk("umul_sol", solution_m[0], 32'hFFFFFFFE);
        chk("umul_stall_cycles", ns, 33);

        // flush mid-multiply, next bundle accepted straight away
        idle_inputs();
        valid_e = 2'b01; multsele = 2'b01; rdata_a[0] = 3; rdata_b[0] = 4;
        run_bundle(10, ns, mr);
        chk("flush_valid", valid_m, 0);
        idle_inputs();
        valid_e = 2'b01; rdata_a[0] = 1; signimme[0] = 1; alusrce[0] = 1; alucontrole[0] = ALU_ADD;
        #1 chk("flush_stall_drop", stall_o, 0);
        run_bundle(-1, ns, mr);
        chk("post_flush_sol", solution_m[0], 32'd2);
        chk("post_flush_nostall", ns, 0);

        // intra-bundle forward
        idle_inputs();
        valid_e = 2'b11; rdata_a[0] = 4; signimme[0] = 5; alusrce[0] = 1; alucontrole[0] = ALU_ADD;
        forwardae[1] = FSELW'(IB); alusrce[1] = 1; alucontrole[1] = ALU_ADD;
        run_bundle(-1, ns, mr);
`ifdef EXEC_INTRA_FWD_EN
        chk("intra_fwd", solution_m[1], 32'd9);
`else
        chk("intra_fwd_off", solution_m[1], 32'd0);
`endif

        // async reset in the middle of a multiply
        idle_inputs();
        valid_e = 2'b01; multsele = 2'b01; rdata_a[0] = 6; rdata_b[0] = 6;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", valid_m, 0);
        chk("rst_sol", solution_m, 0);
        chk("rst_wd", writedata_m, 0);
        chk("rst_wr", writereg_m, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_mr", multready, 0);
        idle_inputs();
        @(posedge clk); #1 reset_n = 1'b1;

        // randomized bundles; the negedge model checks every cycle
        for (int i = 0; i < 250; i++) begin
            rand_bundle(fa);
            run_bundle(fa, ns, mr);
        end
        idle_inputs();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
